uart_digits_tx: RTL and testbench

//   Transmit side of the lab5 UART digit link. On a trigger it snapshots the eight 4-bit digits

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_byte_tx.sv | 124 ++++++++++++
 rtl/uart_digits_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_digits_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the lab5 UART transmit and receive paths.
//   Holds the frame format constants and the FSM state encodings.
//   There are no ports; modules pull this in with import uart_pkg::*.
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;
  localparam int DIGIT_W         = 4;
  localparam logic IDLE_LEVEL    = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx
//   Serializes one byte as an 8N1 frame: start(0), data bits LSB first, stop(1).
//   Every bit is held CLKS_PER_BIT clock cycles.
// Ports
//   clk_i    in   1  clock
//   rst_i    in   1  synchronous, active-high reset
//   load_i   in   1  accept byte_i when ready_o is high
//   byte_i   in   8  byte to send
//   ready_o  out  1  a load is accepted this cycle
//   tx_o     out  1  registered serial line, idle high
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic [FRAME_DATA_BITS-1:0] byte_i,
  output logic                       ready_o,
  output logic                       tx_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(FRAME_DATA_BITS - 1);

  logic [2:0]                 state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [2:0]                 bit_q, bit_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic                       bitEnd;

  assign bitEnd = (baud_q == BAUD_LAST);

  // Ready is also raised in the final cycle of the stop bit, so the next
  // start bit can follow the stop bit with no idle cycle in between.
  assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bitEnd);
  assign tx_o    = tx_q;

  // Bit sequencing: the line value for the next bit is chosen at the
  // moment the current bit expires, keeping tx_o a plain register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_START;
          baud_d  = '0;
          shift_d = byte_i;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bitEnd) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bitEnd) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
            tx_d    = IDLE_LEVEL;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bitEnd) begin
          baud_d = '0;
          if (load_i) begin
            state_d = ST_START;
            shift_d = byte_i;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  // State registers; reset returns the line to idle immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_digits_tx.sv
// uart_digits_tx
//   On a rising trigger edge, snapshots 2*NUM_BYTES 4-bit digits and sends them
//   as NUM_BYTES 8N1 frames, highest digit pair first, with GAP_BITS idle bit
//   periods between frames.
// Ports
//   iclk            in   1   clock
//   transmit_reset  in   1   synchronous, active-high reset
//   transmit_trig   in   1   level trigger; rising edge starts a burst
//   digits_in       in   32  digit k = digits_in[4k+3:4k]
//   uart_transmit   out  1   serial line, idle high
//   busy            out  1   high while a burst is on the line
//   done            out  1   one-cycle pulse after the last stop bit
module uart_digits_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BYTES    = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic                             iclk,
  input  logic                             transmit_reset,
  input  logic                             transmit_trig,
  input  logic [2*NUM_BYTES*DIGIT_W-1:0]   digits_in,
  output logic                             uart_transmit,
  output logic                             busy,
  output logic                             done
);

  localparam int DATA_W = NUM_BYTES * FRAME_DATA_BITS;
  localparam int BIDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GAP_W  = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(NUM_BYTES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // ST_START here stands for "a frame is in the serializer"; the START,
  // DATA and STOP sub-steps live in uart_byte_tx.
  logic [2:0]                 state_q, state_d;
  logic                       trig_q, armed_q;
  logic [DATA_W-1:0]          shadow_q, shadow_d;
  logic [BIDX_W-1:0]          byte_idx_q, byte_idx_d;
  logic [BAUD_W-1:0]          gap_baud_q, gap_baud_d;
  logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       start;
  logic                       txLoad, txReady, selFromInput;
  logic [BIDX_W-1:0]          selIdx;
  logic [DATA_W-1:0]          srcWord;
  logic [FRAME_DATA_BITS-1:0] txByte;

  // armed_q keeps a trigger that is already high when reset releases from
  // counting as an edge; the trigger must be seen low first.
  assign start = transmit_trig && !trig_q && armed_q;

  // Burst sequencing. The first byte comes straight from digits_in because
  // the shadow copy is only written on the same edge.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    byte_idx_d   = byte_idx_q;
    gap_baud_d   = gap_baud_q;
    gap_cnt_d    = gap_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    txLoad       = 1'b0;
    selFromInput = 1'b0;
    selIdx       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_START;
          shadow_d     = digits_in;
          byte_idx_d   = '0;
          busy_d       = 1'b1;
          txLoad       = 1'b1;
          selFromInput = 1'b1;
        end
      end
      ST_START: begin
        if (txReady) begin
          if (byte_idx_q == BYTE_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            if (GAP_BITS == 0) begin
              txLoad = 1'b1;
              selIdx = byte_idx_q + 1'b1;
            end else begin
              state_d    = ST_GAP;
              gap_baud_d = '0;
              gap_cnt_d  = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_baud_q == BAUD_LAST) begin
          gap_baud_d = '0;
          if (gap_cnt_q == GAP_LAST) begin
            state_d = ST_START;
            txLoad  = 1'b1;
            selIdx  = byte_idx_q;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end else begin
          gap_baud_d = gap_baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Frame j carries the digit pair at the top of the word first.
  always_comb begin
    srcWord = selFromInput ? digits_in : shadow_q;
    txByte  = '0;
    for (int j = 0; j < NUM_BYTES; j++) begin
      if (selIdx == BIDX_W'(j)) begin
        txByte = srcWord[DATA_W - FRAME_DATA_BITS*(j+1) +: FRAME_DATA_BITS];
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (transmit_reset) begin
      state_q    <= ST_IDLE;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      shadow_q   <= '0;
      byte_idx_q <= '0;
      gap_baud_q <= '0;
      gap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_q     <= transmit_trig;
      armed_q    <= armed_q || !transmit_trig;
      shadow_q   <= shadow_d;
      byte_idx_q <= byte_idx_d;
      gap_baud_q <= gap_baud_d;
      gap_cnt_q  <= gap_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_i  (iclk),
    .rst_i  (transmit_reset),
    .load_i (txLoad),
    .byte_i (txByte),
    .ready_o(txReady),
    .tx_o   (uart_transmit)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_digits_tx.sv
// tb_uart_digits_tx
//   Self-checking bench for uart_digits_tx. A reference model turns each
//   accepted trigger into the expected per-cycle line waveform (a queue of
//   bits), and a small receiver decodes the line back into bytes.
module tb_uart_digits_tx;

  localparam int CLKS = 10;
  localparam int NB   = 4;
  localparam int GAP  = 1;
  localparam int BURST_LEN = (10*NB + GAP*(NB-1)) * CLKS;

  logic        iclk = 1'b0;
  logic        rst;
  logic        trig;
  logic [31:0] digits;
  logic        uart_transmit;
  logic        busy;
  logic        done;

  uart_digits_tx #(
    .CLKS_PER_BIT(CLKS),
    .NUM_BYTES   (NB),
    .GAP_BITS    (GAP)
  ) dut (
    .iclk          (iclk),
    .transmit_reset(rst),
    .transmit_trig (trig),
    .digits_in     (digits),
    .uart_transmit (uart_transmit),
    .busy          (busy),
    .done          (done)
  );

  always #1 iclk = ~iclk;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  // Reference model state
  bit expQ[$];
  bit expDone   = 1'b0;
  bit mTrigQ    = 1'b0;
  bit mArmed    = 1'b0;
  int acceptCycle = -1;

  // Receiver state
  bit          rxActive = 1'b0;
  int          rxPhase  = 0;
  logic [7:0]  rxShift  = '0;
  logic [7:0]  rxBytes[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
  endtask

  // Expected line bits for a whole burst, built from the digit pairing rule.
  task automatic pushBurst(input logic [31:0] d);
    logic [3:0] hi, lo;
    logic [7:0] b;
    for (int j = 0; j < NB; j++) begin
      hi = d[4*(7-2*j) +: 4];
      lo = d[4*(6-2*j) +: 4];
      b  = {hi, lo};
      repeat (CLKS) expQ.push_back(1'b0);
      for (int k = 0; k < 8; k++) repeat (CLKS) expQ.push_back(b[k]);
      repeat (CLKS) expQ.push_back(1'b1);
      if (j < NB-1) repeat (GAP*CLKS) expQ.push_back(1'b1);
    end
  endtask

  task automatic stepCycle();
    bit wasEmpty, startEdge;
    int idx;
    @(posedge iclk);
    cycle++;
    if (rst) begin
      expQ.delete();
      expDone     = 1'b0;
      mTrigQ      = 1'b0;
      mArmed      = 1'b0;
      acceptCycle = -1;
    end else begin
      wasEmpty = (expQ.size() == 0);
      if (!wasEmpty) void'(expQ.pop_front());
      expDone   = !wasEmpty && (expQ.size() == 0);
      startEdge = trig && !mTrigQ && mArmed;
      if (wasEmpty && startEdge) begin
        pushBurst(digits);
        acceptCycle = cycle;
      end
      mArmed = mArmed || !trig;
      mTrigQ = trig;
    end
    @(negedge iclk);
    checkOutput("line", uart_transmit, (expQ.size() != 0) ? expQ[0] : 1'b1);
    checkOutput("busy", busy, expQ.size() != 0);
    checkOutput("done", done, expDone);
    if (done === 1'b1 && acceptCycle >= 0)
      checkOutput("doneLatency", cycle + 1 - acceptCycle, BURST_LEN + 1);
    if (rst) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (uart_transmit === 1'b0) begin
        rxActive = 1'b1;
        rxPhase  = 0;
      end
    end else begin
      rxPhase++;
      if (rxPhase % CLKS == CLKS/2) begin
        idx = rxPhase / CLKS;
        if (idx >= 1 && idx <= 8) begin
          rxShift[idx-1] = uart_transmit;
        end else if (idx == 9) begin
          checkOutput("rxStop", uart_transmit, 1'b1);
          rxBytes.push_back(rxShift);
          rxActive = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic [31:0] d, input int n);
    rst    = r;
    trig   = t;
    digits = d;
    repeat (n) stepCycle();
  endtask

  task automatic checkBytes(input string tag, input logic [31:0] word);
    checkOutput({tag, "Count"}, rxBytes.size(), 4);
    if (rxBytes.size() == 4) begin
      for (int j = 0; j < 4; j++)
        checkOutput({tag, "Byte"}, rxBytes[j], word[8*(3-j) +: 8]);
    end
  endtask

  initial begin
    logic [31:0] w, d;
    rst = 1'b1; trig = 1'b1; digits = '0;

    $display("[TB] reset with trigger held high");
    applyStimulus(1, 1, 32'h0, 3);
    applyStimulus(0, 1, 32'h0, 20);
    checkOutput("noBurstAfterReset", rxBytes.size(), 0);
    applyStimulus(0, 0, 32'h0, 5);

    $display("[TB] digits 1..8");
    rxBytes.delete();
    applyStimulus(0, 1, 32'h8765_4321, 1);
    applyStimulus(0, 0, 32'h8765_4321, 440);
    checkBytes("digits18", 32'h8765_4321);

    $display("[TB] held trigger, lost mid-burst edge, digit latch");
    rxBytes.delete();
    applyStimulus(0, 1, 32'hA5C3_1E7F, 1);
    applyStimulus(0, 1, 32'hA5C3_1E7F, 4);
    applyStimulus(0, 1, 32'h0, 93);
    applyStimulus(0, 0, 32'h0, 2);
    applyStimulus(0, 1, 32'h0, 1900);
    checkBytes("heldTrig", 32'hA5C3_1E7F);

    $display("[TB] reset inside frame 0");
    applyStimulus(0, 0, 32'h0, 3);
    rxBytes.delete();
    applyStimulus(0, 1, 32'h9ABC_DEF0, 1);
    applyStimulus(0, 1, 32'h9ABC_DEF0, 56);
    applyStimulus(1, 1, 32'h9ABC_DEF0, 1);
    applyStimulus(0, 1, 32'h9ABC_DEF0, 10);
    checkOutput("abortedFrames", rxBytes.size(), 0);
    applyStimulus(0, 0, 32'h0, 2);

    $display("[TB] loop-back 0x12345678");
    rxBytes.delete();
    applyStimulus(0, 1, 32'h1234_5678, 1);
    applyStimulus(0, 0, 32'h1234_5678, 430);
    applyStimulus(0, 1, 32'h0F1E_2D3C, 1);
    w = '0;
    if (rxBytes.size() >= 4)
      for (int j = 0; j < 4; j++) begin
        w[4*(7-2*j) +: 4] = rxBytes[j][7:4];
        w[4*(6-2*j) +: 4] = rxBytes[j][3:0];
      end
    checkOutput("loopback", w, 32'h1234_5678);

    $display("[TB] edge in done cycle starts a second burst");
    rxBytes.delete();
    applyStimulus(0, 0, 32'h0, 440);
    checkBytes("backToBack", 32'h0F1E_2D3C);

    $display("[TB] random triggers");
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      applyStimulus(0, 1, d, $urandom_range(1, 500));
      applyStimulus(0, 0, $urandom, $urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) applyStimulus(1, $urandom_range(0, 1), d, 1);
    end
    applyStimulus(0, 0, 32'h0, 450);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
